// File: rtl/nibble_sched_pkg.sv
// Shared types and constants for the nibble-serial adder scheduler.
package nibble_sched_pkg;

  localparam int NIBBLE_W = 4;
  localparam int ID_W     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_4bit.sv
// Plain 4-bit ripple-carry adder, used as the shared nibble datapath.
module full_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign Sum[gi]  = A[gi] ^ B[gi] ^ c[gi];
    assign c[gi+1]  = (A[gi] & B[gi]) | (c[gi] & (A[gi] ^ B[gi]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/nibble_adder_sched.sv
// Two-requester round-robin scheduler that performs WIDTH-bit additions one
// nibble per cycle on a single shared 4-bit adder.
module nibble_adder_sched
  import nibble_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_last_q, rr_last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  nib_idx_q, nib_idx_d;

  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [WIDTH-1:0]  a_shift, b_shift;
  logic [NIBBLE_W-1:0] fa_sum;
  logic              fa_cout;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = ID_W'(0);
    if (req0_valid && req1_valid) begin
      grant_id = ~rr_last_q;
    end else if (req1_valid) begin
      grant_id = ID_W'(1);
    end
  end

  assign req0_ready = (state_q == IDLE) && grant_valid && (grant_id == ID_W'(0));
  assign req1_ready = (state_q == IDLE) && grant_valid && (grant_id == ID_W'(1));

  assign a_shift = a_q >> (int'(nib_idx_q) * NIBBLE_W);
  assign b_shift = b_q >> (int'(nib_idx_q) * NIBBLE_W);

  full_adder_4bit u_fa (
    .A    (a_shift[NIBBLE_W-1:0]),
    .B    (b_shift[NIBBLE_W-1:0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    nib_idx_d = nib_idx_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          a_d       = (grant_id == ID_W'(1)) ? req1_a   : req0_a;
          b_d       = (grant_id == ID_W'(1)) ? req1_b   : req0_b;
          carry_d   = (grant_id == ID_W'(1)) ? req1_cin : req0_cin;
          id_d      = grant_id;
          rr_last_d = grant_id;
          sum_d     = '0;
          nib_idx_d = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < NIB; i++) begin
          if (nib_idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = fa_sum;
        end
        carry_d   = fa_cout;
        nib_idx_d = nib_idx_q + IDX_W'(1);
        if (nib_idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= ID_W'(1);
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      nib_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      nib_idx_q <= nib_idx_d;
    end
  end

  // After the last nibble the carry register holds the MSB carry-out.
  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_nibble_adder_sched.sv
// Scoreboard bench for nibble_adder_sched (16-bit instance plus an 8-bit instance).
module tb_nibble_adder_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [15:0] rsp_sum;

  logic        n8_req0_valid, n8_req0_ready, n8_req0_cin;
  logic        n8_req1_valid, n8_req1_ready, n8_req1_cin;
  logic [7:0]  n8_req0_a, n8_req0_b, n8_req1_a, n8_req1_b;
  logic        n8_rsp_valid, n8_rsp_ready, n8_rsp_cout, n8_rsp_id;
  logic [7:0]  n8_rsp_sum;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  nibble_adder_sched #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  nibble_adder_sched #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(n8_req0_valid), .req0_ready(n8_req0_ready), .req0_a(n8_req0_a), .req0_b(n8_req0_b), .req0_cin(n8_req0_cin),
    .req1_valid(n8_req1_valid), .req1_ready(n8_req1_ready), .req1_a(n8_req1_a), .req1_b(n8_req1_b), .req1_cin(n8_req1_cin),
    .rsp_valid(n8_rsp_valid), .rsp_ready(n8_rsp_ready), .rsp_sum(n8_rsp_sum), .rsp_cout(n8_rsp_cout), .rsp_id(n8_rsp_id)
  );

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic id);
    logic [16:0] s;
    exp_t e;
    s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.sum  = s[15:0];
    e.cout = s[16];
    e.id   = id;
    return e;
  endfunction

  // Present a request until accepted; returns just after the accepting edge's following negedge.
  task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      if ((id && req1_ready) || (!id && req0_ready)) begin
        ok = 1'b1;
        exp_q.push_back(model(a, b, cin, id));
      end
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Latency counted in rising edges from the accepting edge (that edge counts as 1).
  task automatic wait_rsp(output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b id=%b, want 0/0000/0/0", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got r0=%b r1=%b, want 0 0 with no valid", req0_ready, req1_ready);
    end
  endtask

  task automatic run_one(input string name, input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] want_sum, input logic want_cout);
    bit   ok;
    int   lat;
    exp_t e;
    rsp_ready = 1'b0;
    issue(id, a, b, cin, ok);
    wait_rsp(lat, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: got no rsp_valid, want response", name);
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL %s_latency: got %0d, want 5", name, lat);
    end
    total++;
    if (rsp_sum !== want_sum || rsp_cout !== want_cout || rsp_id !== id) begin
      bad++;
      $display("FAIL %s_value: got sum=%h cout=%b id=%b, want sum=%h cout=%b id=%b",
               name, rsp_sum, rsp_cout, rsp_id, want_sum, want_cout, id);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    total++;
    if ({rsp_sum, rsp_cout, rsp_id} !== e) begin
      bad++;
      $display("FAIL %s_scoreboard: got %h/%b/%b, want %h/%b/%b", name, rsp_sum, rsp_cout, rsp_id, e.sum, e.cout, e.id);
    end
    $display("op %s: id=%0d a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d", name, id, a, b, cin, rsp_sum, rsp_cout, lat);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_rsp_clear: got rsp_valid=%b, want 0", name, rsp_valid);
    end
  endtask

  task automatic test_basic();
    run_one("basic", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0);
  endtask

  task automatic test_carry();
    run_one("wrap", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_one("chain", 1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a0[4], b0[4], a1[4], b1[4];
    logic        c0[4], c1[4];
    int n0 = 0, n1 = 0, nrsp = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      a0[i] = 16'($urandom); b0[i] = 16'($urandom); c0[i] = 1'($urandom);
      a1[i] = 16'($urandom); b1[i] = 16'($urandom); c1[i] = 1'($urandom);
    end
    apply_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 200 && nrsp < 8; c++) begin
      req0_valid = (n0 < 4);
      req0_a = a0[(n0 < 4) ? n0 : 3]; req0_b = b0[(n0 < 4) ? n0 : 3]; req0_cin = c0[(n0 < 4) ? n0 : 3];
      req1_valid = (n1 < 4);
      req1_a = a1[(n1 < 4) ? n1 : 3]; req1_b = b1[(n1 < 4) ? n1 : 3]; req1_cin = c1[(n1 < 4) ? n1 : 3];
      #1;
      total++;
      if (req0_ready && req1_ready) begin
        bad++;
        $display("FAIL both_ready: got r0=1 r1=1, want at most one");
      end
      if (req0_ready) begin
        exp_q.push_back(model(req0_a, req0_b, req0_cin, 1'b0));
        n0++;
      end else if (req1_ready) begin
        exp_q.push_back(model(req1_a, req1_b, req1_cin, 1'b1));
        n1++;
      end
      if (rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total++;
        if ({rsp_sum, rsp_cout, rsp_id} !== e) begin
          bad++;
          $display("FAIL b2b_scoreboard[%0d]: got %h/%b/%b, want %h/%b/%b", nrsp, rsp_sum, rsp_cout, rsp_id, e.sum, e.cout, e.id);
        end
        total++;
        if (rsp_id !== 1'(nrsp % 2)) begin
          bad++;
          $display("FAIL b2b_order[%0d]: got id=%b, want %0d", nrsp, rsp_id, nrsp % 2);
        end
        $display("b2b rsp %0d: id=%b sum=%h cout=%b", nrsp, rsp_id, rsp_sum, rsp_cout);
        nrsp++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    total++;
    if (nrsp != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d responses, want 8", nrsp);
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    int          lat;
    logic [15:0] s;
    logic        co, id;
    exp_t        e;
    rsp_ready = 1'b0;
    issue(1'b0, 16'h4321, 16'h1111, 1'b1, ok);
    wait_rsp(lat, ok);
    s = rsp_sum; co = rsp_cout; id = rsp_id;
    req1_valid = 1'b1; req1_a = 16'h0F0F; req1_b = 16'h0101; req1_cin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== s || rsp_cout !== co || rsp_id !== id) begin
        bad++;
        $display("FAIL hold_stable[%0d]: got %b/%h/%b/%b, want 1/%h/%b/%b", c, rsp_valid, rsp_sum, rsp_cout, rsp_id, s, co, id);
      end
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_ready[%0d]: got r0=%b r1=%b, want 0 0", c, req0_ready, req1_ready);
      end
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    total++;
    if ({rsp_sum, rsp_cout, rsp_id} !== e) begin
      bad++;
      $display("FAIL hold_scoreboard: got %h/%b/%b, want %h/%b/%b", rsp_sum, rsp_cout, rsp_id, e.sum, e.cout, e.id);
    end
    $display("hold: sum=%h cout=%b id=%b held 3 cycles", rsp_sum, rsp_cout, rsp_id);
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: got rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    bit   ok;
    int   lat;
    int   seen = 0;
    exp_t e;
    rsp_ready = 1'b1;
    issue(1'b1, 16'h1119, 16'h1118, 1'b0, ok);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got %b/%h/%b/%b, want 0/0000/0/0", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_no_rsp: got %0d rsp_valid cycles, want 0", seen);
    end
    req0_valid = 1'b1; req0_a = 16'h0007; req0_b = 16'h0009; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0100; req1_b = 16'h0200; req1_cin = 1'b0;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_tie: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    if (req0_ready) exp_q.push_back(model(req0_a, req0_b, req0_cin, 1'b0));
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    total++;
    if (!ok || {rsp_sum, rsp_cout, rsp_id} !== e) begin
      bad++;
      $display("FAIL midreset_op: got ok=%b %h/%b/%b, want %h/%b/%b", ok, rsp_sum, rsp_cout, rsp_id, e.sum, e.cout, e.id);
    end
    $display("post-reset tie: id=%b sum=%h", rsp_id, rsp_sum);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_width8();
    bit ok = 1'b0;
    int lat = 0;
    bit got = 1'b0;
    @(negedge clk);
    n8_rsp_ready = 1'b1;
    n8_req0_valid = 1'b1; n8_req0_a = 8'hF0; n8_req0_b = 8'h10; n8_req0_cin = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (n8_req0_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    n8_req0_valid = 1'b0;
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (n8_rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    total++;
    if (!ok || !got || lat != 3) begin
      bad++;
      $display("FAIL w8_latency: got accepted=%b valid=%b lat=%0d, want 1 1 3", ok, got, lat);
    end
    total++;
    if (n8_rsp_sum !== 8'h01 || n8_rsp_cout !== 1'b1 || n8_rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL w8_value: got sum=%h cout=%b id=%b, want 01 1 0", n8_rsp_sum, n8_rsp_cout, n8_rsp_id);
    end
    $display("w8 op: a=f0 b=10 cin=1 -> sum=%h cout=%b lat=%0d", n8_rsp_sum, n8_rsp_cout, lat);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b0;
    n8_req0_valid = 1'b0; n8_req0_a = '0; n8_req0_b = '0; n8_req0_cin = 1'b0;
    n8_req1_valid = 1'b0; n8_req1_a = '0; n8_req1_b = '0; n8_req1_cin = 1'b0;
    n8_rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
